// File: rtl/aes_pkg.sv
// aes_pkg: shared types, FSM encoding and AES arithmetic helpers.
//   aes_128 / aes_32   : block and column types, byte 0 is the MSB
//   aes_fsm_e          : sequencer states IDLE / ROUND / DONE
//   RCON_INIT          : first round constant
//   sub_bytes_byte()   : S-box built in GF((2^4)^2), no lookup table
//   mix_column()       : one MixColumns column, xtime and XOR only
package aes_pkg;

    typedef logic [127:0] aes_128;
    typedef logic [31:0]  aes_32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_fsm_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) -> GF((2^4)^2) basis change.
    function automatic logic [7:0] isomorph(input logic [7:0] a);
        logic [7:0] q;
        q[7] = a[7] ^ a[5];
        q[6] = a[7] ^ a[6] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
        q[5] = a[7] ^ a[5] ^ a[3] ^ a[2];
        q[4] = a[7] ^ a[5] ^ a[3] ^ a[2] ^ a[1];
        q[3] = a[7] ^ a[6] ^ a[2] ^ a[1];
        q[2] = a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
        q[1] = a[6] ^ a[4] ^ a[1];
        q[0] = a[6] ^ a[1] ^ a[0];
        return q;
    endfunction

    // GF((2^4)^2) -> GF(2^8) basis change.
    function automatic logic [7:0] inv_isomorph(input logic [7:0] q);
        logic [7:0] a;
        a[7] = q[7] ^ q[6] ^ q[5] ^ q[1];
        a[6] = q[6] ^ q[2];
        a[5] = q[6] ^ q[5] ^ q[1];
        a[4] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1];
        a[3] = q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        a[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        a[1] = q[5] ^ q[4];
        a[0] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0];
        return a;
    endfunction

    function automatic logic [3:0] square_nibble(input logic [3:0] q);
        return {q[3], q[3] ^ q[2], q[2] ^ q[1], q[3] ^ q[1] ^ q[0]};
    endfunction

    // Multiply by lambda = {1100}.
    function automatic logic [3:0] mul_lambda(input logic [3:0] q);
        return {q[2] ^ q[0], q[3] ^ q[2] ^ q[1] ^ q[0], q[3], q[2]};
    endfunction

    // GF(2^2) multiply modulo x^2+x+1.
    function automatic logic [1:0] mul_gf2(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]),
                (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    // Multiply by phi = {10} in GF(2^2).
    function automatic logic [1:0] mul_phi(input logic [1:0] q);
        return {q[1] ^ q[0], q[1]};
    endfunction

    // GF(2^4) multiply over GF(2^2), modulo y^2+y+phi.
    function automatic logic [3:0] mul_gf4(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh, hl, lh, ll;
        hh = mul_gf2(a[3:2], b[3:2]);
        hl = mul_gf2(a[3:2], b[1:0]);
        lh = mul_gf2(a[1:0], b[3:2]);
        ll = mul_gf2(a[1:0], b[1:0]);
        return {hh ^ hl ^ lh, mul_phi(hh) ^ ll};
    endfunction

    // Inverse as q^14 = q^2 * q^4 * q^8; maps 0 to 0 as the S-box needs.
    function automatic logic [3:0] invert_nibble(input logic [3:0] q);
        logic [3:0] q2, q4, q8;
        q2 = square_nibble(q);
        q4 = square_nibble(q2);
        q8 = square_nibble(q4);
        return mul_gf4(mul_gf4(q2, q4), q8);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // (h*Y + l)^-1 = h*d*Y + (h^l)*d with d = (h^2*lambda + (h^l)*l)^-1.
    function automatic logic [7:0] sub_bytes_byte(input logic [7:0] a);
        logic [7:0] t;
        logic [3:0] ah, al, d, di;
        t  = isomorph(a);
        ah = t[7:4];
        al = t[3:0];
        d  = mul_lambda(square_nibble(ah)) ^ mul_gf4(ah ^ al, al);
        di = invert_nibble(d);
        return affine(inv_isomorph({mul_gf4(ah, di), mul_gf4(ah ^ al, di)}));
    endfunction

    function automatic aes_32 mix_column(input aes_32 c);
        logic [7:0] b0, b1, b2, b3;
        b0 = c[31:24];
        b1 = c[23:16];
        b2 = c[15:8];
        b3 = c[7:0];
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

endpackage

// File: rtl/aes_round_core.sv
// aes_round_core: one AES-128 encryption round plus one key-schedule step,
// purely combinational.
//   state, rkey : current state and current round key
//   rcon        : round constant for this key step
//   last        : final round, MixColumns skipped
//   next_state  : SubBytes/ShiftRows/[MixColumns]/AddRoundKey(next_key)
//   next_key    : round key derived from rkey and rcon
module aes_round_core
    import aes_pkg::*;
(
    input  aes_128     state,
    input  aes_128     rkey,
    input  logic [7:0] rcon,
    input  logic       last,
    output aes_128     next_state,
    output aes_128     next_key
);

    aes_128 sb;
    aes_128 sr;
    aes_128 mc;
    aes_32  w3_rot;
    aes_32  temp;
    aes_32  n0, n1, n2, n3;

    always_comb begin
        // Key step: RotWord, SubWord, rcon into the top byte, then chain words.
        w3_rot = {rkey[23:0], rkey[31:24]};
        temp   = '0;
        for (int i = 0; i < 4; i++) begin
            temp[31-8*i -: 8] = sub_bytes_byte(w3_rot[31-8*i -: 8]);
        end
        temp[31:24] = temp[31:24] ^ rcon;
        n0 = rkey[127:96] ^ temp;
        n1 = rkey[95:64]  ^ n0;
        n2 = rkey[63:32]  ^ n1;
        n3 = rkey[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};

        sb = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = sub_bytes_byte(state[127-8*i -: 8]);
        end

        // Bytes are column-major: byte 4c+r sits at row r, column c.
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end

        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end

        next_state = (last ? sr : mc) ^ next_key;
    end

endmodule

// File: rtl/aes_enc_sequencer.sv
// aes_enc_sequencer: iterative AES-128 encryptor, one round per clock.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : job handshake; plaintext and key sampled at accept
//   out_valid / out_ready: result handshake; ciphertext held until taken
//   busy                 : FSM is not IDLE
// Accept-to-out_valid latency is NUM_ROUNDS cycles; a block is retired
// every NUM_ROUNDS+2 cycles with out_ready held high.
module aes_enc_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  aes_128 plaintext,
    input  aes_128 key,
    output logic   out_valid,
    input  logic   out_ready,
    output aes_128 ciphertext,
    output logic   busy
);

    aes_fsm_e   fsm_q, fsm_d;
    aes_128     state_q, state_d;
    aes_128     rkey_q, rkey_d;
    logic [7:0] rcon_q, rcon_d;
    logic [3:0] round_q, round_d;
    // Low in reset and for the first edge after it, so in_ready rises only
    // once the block has seen a clock out of reset.
    logic       live_q, live_d;

    logic       accept;
    logic       last;
    aes_128     next_state;
    aes_128     next_key;

    assign last   = (round_q == 4'(NUM_ROUNDS));
    assign accept = in_valid && in_ready;
    assign live_d = 1'b1;

    aes_round_core u_core (
        .state      (state_q),
        .rkey       (rkey_q),
        .rcon       (rcon_q),
        .last       (last),
        .next_state (next_state),
        .next_key   (next_key)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            live_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            live_q <= live_d;
        end
    end

    // FSM next state
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:  if (accept)    fsm_d = ST_ROUND;
            ST_ROUND: if (last)      fsm_d = ST_DONE;
            ST_DONE:  if (out_ready) fsm_d = ST_IDLE;
            default:                 fsm_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready   = (fsm_q == ST_IDLE) && live_q;
        out_valid  = (fsm_q == ST_DONE);
        busy       = (fsm_q != ST_IDLE);
        ciphertext = out_valid ? state_q : '0;
    end

    // Datapath next values
    always_comb begin
        state_d = state_q;
        rkey_d  = rkey_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        if (fsm_q == ST_IDLE && accept) begin
            state_d = plaintext ^ key;
            rkey_d  = key;
            rcon_d  = RCON_INIT;
            round_d = 4'd1;
        end else if (fsm_q == ST_ROUND) begin
            state_d = next_state;
            rkey_d  = next_key;
            rcon_d  = xtime(rcon_q);
            round_d = round_q + 4'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            rkey_q  <= '0;
            rcon_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            rkey_q  <= rkey_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
        end
    end

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Directed bench for aes_enc_sequencer with a scoreboard queue of expected
// ciphertexts (FIPS-197 App. B and C.1 vectors).
module tb_aes_enc_sequencer;
    localparam int NR = 10;

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] ciphertext;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [127:0] sb[$];

    aes_enc_sequencer #(.NUM_ROUNDS(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a job at a falling edge, accept on the next rising edge,
    // return at the following falling edge (round 1 in flight).
    task automatic accept_job(input logic [127:0] pt, input logic [127:0] k,
                              input logic [127:0] exp, input string tag);
        @(negedge clk);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Cycles until out_valid, sampled on falling edges; bounded.
    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_out_valid"}, out_valid, 1);
    endtask

    task automatic check_pop(input string tag);
        logic [127:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            exp = sb.pop_front();
            chk(tag, ciphertext, exp);
        end
    endtask

    initial begin
        int lat;
        int outs;
        int nacc;
        int acc_cyc[2];
        logic seen;
        logic [127:0] tbl_pt[2];
        logic [127:0] tbl_k[2];
        logic [127:0] tbl_ct[2];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ciphertext", ciphertext, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready_pre_edge", in_ready, 0);
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // App. B with backpressure
        out_ready = 1'b0;
        accept_job(PB, KB, CB, "appb");
        wait_out("appb", lat);
        chk("appb_latency", lat, NR);
        check_pop("appb_ct");
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("bp_ct_stable", ciphertext, CB);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_busy", busy, 0);
        chk("bp_release_in_ready", in_ready, 1);

        // App. C.1 with in_valid toggling new data while in ROUND
        accept_job(PC, KC, CC, "appc");
        for (int i = 0; i < 5; i++) begin
            in_valid  = ~in_valid;
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("appc_busy", busy, 1);
        end
        in_valid = 1'b0;
        wait_out("appc", lat);
        check_pop("appc_ct");
        @(negedge clk);
        chk("appc_one_cycle_valid", out_valid, 0);

        // Reset in the middle of a job
        accept_job(PC, KC, CC, "abort");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_ciphertext", ciphertext, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("abort_no_out_valid", seen, 0);
        accept_job(PB, KB, CB, "after_abort");
        wait_out("after_abort", lat);
        chk("after_abort_latency", lat, NR);
        check_pop("after_abort_ct");

        // Back-to-back with in_valid held high
        tbl_pt[0] = PB; tbl_k[0] = KB; tbl_ct[0] = CB;
        tbl_pt[1] = PC; tbl_k[1] = KC; tbl_ct[1] = CC;
        outs = 0;
        nacc = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        for (int c = 0; c < 80 && outs < 2; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check_pop("b2b_ct");
                outs++;
            end
            if (nacc < 2) begin
                plaintext = tbl_pt[nacc];
                key       = tbl_k[nacc];
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                acc_cyc[nacc] = cyc;
                sb.push_back(tbl_ct[nacc]);
                nacc++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_outputs", outs, 2);
        chk("b2b_accepts", nacc, 2);
        chk("b2b_accept_gap", acc_cyc[1] - acc_cyc[0], NR + 2);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
